// File: rtl/seg_scan_decoder_if.sv
// Bus bundle between the 7-segment scan lines and the scan decoder.
// The master side drives the scan lines and clear. The slave side (the decoder)
// drives the decoded digit store, the frame snapshot and the error flags.
interface seg_scan_decoder_if;
    logic [7:0]  anode;
    logic [6:0]  cathode;
    logic        clear;
    logic [31:0] digits;
    logic [7:0]  seen;
    logic [31:0] frame_data;
    logic        frame_valid;
    logic        pat_err;
    logic        anode_err;

    modport master (
        output anode, cathode, clear,
        input  digits, seen, frame_data, frame_valid, pat_err, anode_err
    );

    modport slave (
        input  anode, cathode, clear,
        output digits, seen, frame_data, frame_valid, pat_err, anode_err
    );
endinterface

// File: rtl/seg_scan_decoder.sv
// Receive-side decoder for a multiplexed 8-digit, active-low 7-segment scan.
// Each scan slot must hold steady for SETTLE_CYCLES edges before it is decoded.
// Decoded nibbles go into a live digit store. A full set of eight digits is
// snapshotted into frame_data. Bad anode or cathode patterns raise sticky flags.
module seg_scan_decoder #(
    parameter int SETTLE_CYCLES = 16,
    parameter int CNT_W         = 8
) (
    input logic               clk,
    input logic               reset,
    seg_scan_decoder_if.slave bus
);

    typedef enum logic [1:0] {ST_WAIT, ST_CAPTURE, ST_HOLD} state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SETTLE_CYCLES - 1);

    state_t           state_q, state_d;
    logic [14:0]      sample_q;
    logic [14:0]      sampleIn;
    logic             changed;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [31:0]      digits_q, digits_d;
    logic [7:0]       seen_q, seen_d;
    logic [31:0]      frame_data_q, frame_data_d;
    logic             frame_valid_q, frame_valid_d;
    logic             pend_q, pend_d;
    logic             pat_err_q, pat_err_d;
    logic             anode_err_q, anode_err_d;

    logic [7:0]       anodeLow;
    logic             blank;
    logic             oneCold;
    logic [2:0]       digitIdx;
    logic             decValid;
    logic [3:0]       decNibble;

    assign sampleIn = {bus.anode, bus.cathode};
    assign changed  = (sampleIn != sample_q);

    // Cathode pattern (gfedcba, active-low) back to a hex nibble; bit 4 marks a known glyph.
    function automatic logic [4:0] decodeSeg(input logic [6:0] seg);
        case (seg)
            7'h40:   decodeSeg = {1'b1, 4'h0};
            7'h79:   decodeSeg = {1'b1, 4'h1};
            7'h24:   decodeSeg = {1'b1, 4'h2};
            7'h30:   decodeSeg = {1'b1, 4'h3};
            7'h19:   decodeSeg = {1'b1, 4'h4};
            7'h12:   decodeSeg = {1'b1, 4'h5};
            7'h02:   decodeSeg = {1'b1, 4'h6};
            7'h78:   decodeSeg = {1'b1, 4'h7};
            7'h00:   decodeSeg = {1'b1, 4'h8};
            7'h10:   decodeSeg = {1'b1, 4'h9};
            7'h08:   decodeSeg = {1'b1, 4'hA};
            7'h03:   decodeSeg = {1'b1, 4'hB};
            7'h46:   decodeSeg = {1'b1, 4'hC};
            7'h21:   decodeSeg = {1'b1, 4'hD};
            7'h06:   decodeSeg = {1'b1, 4'hE};
            7'h0E:   decodeSeg = {1'b1, 4'hF};
            default: decodeSeg = 5'h00;
        endcase
    endfunction

    // Register the sampled lines, settle counter and scan state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sample_q <= 15'h7FFF;
            cnt_q    <= '0;
            state_q  <= ST_WAIT;
        end else begin
            if (changed) begin
                sample_q <= sampleIn;
            end
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

    // Any change restarts settling; a full settle grants one capture cycle, then hold.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (changed) begin
            state_d = ST_WAIT;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_WAIT: begin
                    if (cnt_q == LAST_CNT) begin
                        state_d = ST_CAPTURE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_CAPTURE: state_d = ST_HOLD;
                ST_HOLD:    state_d = ST_HOLD;
                default:    state_d = ST_WAIT;
            endcase
        end
    end

    // Classify the captured anode lines and decode the captured cathode pattern.
    always_comb begin
        anodeLow = ~sample_q[14:7];
        blank    = (anodeLow == 8'h00);
        oneCold  = !blank && ((anodeLow & (anodeLow - 8'd1)) == 8'h00);
        digitIdx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (anodeLow[i]) begin
                digitIdx = 3'(i);
            end
        end
        {decValid, decNibble} = decodeSeg(sample_q[6:0]);
    end

    // Update the digit store, frame bookkeeping and sticky flags; clear wins over capture.
    always_comb begin
        digits_d      = digits_q;
        seen_d        = seen_q;
        frame_data_d  = frame_data_q;
        frame_valid_d = 1'b0;
        pat_err_d     = pat_err_q;
        anode_err_d   = anode_err_q;

        if (pend_q && !bus.clear) begin
            frame_data_d  = digits_q;
            frame_valid_d = 1'b1;
            seen_d        = 8'h00;
        end

        if (state_q == ST_CAPTURE) begin
            if (oneCold) begin
                if (decValid) begin
                    digits_d[{digitIdx, 2'b00} +: 4] = decNibble;
                    seen_d[digitIdx]                 = 1'b1;
                end else begin
                    pat_err_d = 1'b1;
                end
            end else if (!blank) begin
                anode_err_d = 1'b1;
            end
        end

        if (bus.clear) begin
            seen_d      = 8'h00;
            pat_err_d   = 1'b0;
            anode_err_d = 1'b0;
        end

        pend_d = (state_q == ST_CAPTURE) && (seen_d == 8'hFF);
    end

    // Register the decoded outputs and the pending-frame flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            digits_q      <= '0;
            seen_q        <= '0;
            frame_data_q  <= '0;
            frame_valid_q <= 1'b0;
            pend_q        <= 1'b0;
            pat_err_q     <= 1'b0;
            anode_err_q   <= 1'b0;
        end else begin
            digits_q      <= digits_d;
            seen_q        <= seen_d;
            frame_data_q  <= frame_data_d;
            frame_valid_q <= frame_valid_d;
            pend_q        <= pend_d;
            pat_err_q     <= pat_err_d;
            anode_err_q   <= anode_err_d;
        end
    end

    assign bus.digits      = digits_q;
    assign bus.seen        = seen_q;
    assign bus.frame_data  = frame_data_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.pat_err     = pat_err_q;
    assign bus.anode_err   = anode_err_q;

endmodule

// File: doc/seg_scan_decoder.md
Name: seg_scan_decoder

Overview:
Receive-side decoder for the multiplexed 8-digit 7-segment scan interface (active-low anodes, active-low cathodes). It samples the anode/cathode lines, waits for each scan slot to be stable, and decodes the cathode pattern back to a hex nibble for the active digit. It assembles a 32-bit frame and flags protocol errors. It serves as a loopback checker and display mirror beside the scan driver on the FPGA top level.

Parameters:
SETTLE_CYCLES, 16, consecutive clk edges the sampled pattern must stay unchanged before capture (legal range 2..255)
CNT_W, 8, width of the settle counter (must satisfy 2^CNT_W > SETTLE_CYCLES)

Ports:
clk  input  1  system clock (100 MHz)
reset  input  1  asynchronous, active-high reset
anode  input  8  scan anodes, active-low; bit i low selects digit i
cathode  input  7  segments, active-low, [6]=g [5]=f [4]=e [3]=d [2]=c [1]=b [0]=a
clear  input  1  synchronous; clears seen, pat_err, anode_err
digits  output  32  live digit store; digit i at [4i+3:4i]
seen  output  8  bit i set once digit i has been captured in the current frame
frame_data  output  32  snapshot of digits at frame completion
frame_valid  output  1  one-cycle pulse when frame_data updates
pat_err  output  1  sticky: stable cathode pattern not in the decode table
anode_err  output  1  sticky: stable anode pattern neither all-ones nor one-cold

Behaviour:
- Reset (async): all outputs 0, settle counter 0, state WAIT, sample register = 15'h7FFF.
- Sample register S holds {anode,cathode}. On every edge where input != S, S is loaded, the counter is cleared, and the state becomes WAIT.
- FSM:
  - WAIT: counter increments on each edge where input == S. When it reaches SETTLE_CYCLES-1, go to CAPTURE.
  - CAPTURE: lasts one cycle, acts on S, then goes to HOLD.
  - HOLD: no further capture until the input changes (then back to WAIT).
- Capture latency: after a change followed by a stable input, the capture edge is exactly SETTLE_CYCLES+1 edges after the change edge.
- Anode classification at capture:
  - all ones (blank): no action, no error.
  - exactly one bit low at index i: decode cathode.
  - any other pattern: anode_err<=1, no digit update.
- Cathode decode, hex for gfedcba active-low:
  - 0=40, 1=79, 2=24, 3=30
  - 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03
  - C=46, d=21, E=06, F=0E
- Valid decode: digits[4i+3:4i]<=nibble and seen[i]<=1 on the capture edge.
- Invalid pattern: pat_err<=1; digit and seen unchanged.
- Frame completion: if a capture makes seen==8'hFF, then on the next edge frame_data<=digits, frame_valid=1 for one cycle, and seen<=0. Digit capture order is irrelevant. A repeated capture of the same digit within a frame overwrites the nibble (last value wins).
- clear: takes priority over capture-set of seen and error flags in the same cycle. digits, frame_data and FSM are unaffected. A frame completion pending in the same cycle as clear is cancelled.
- Reset mid-frame discards partial seen state and stored digits.
- Inputs are treated as synchronous to clk; no synchroniser inside.

Test Plan:
- Reset, then drive anode=FE, cathode=24 held 40 cycles -> digits[3:0]=2 and seen=01 at exactly edge SETTLE_CYCLES+1 after the change; no errors.
- Drive digits 0..7 with values 1,2,3,4,5,6,7,8, each held 20 cycles, in order 7..0 -> one frame_valid pulse, frame_data=32'h87654321, seen returns to 00.
- Glitch: anode=FD, cathode=30 held 10 cycles, then cathode=19 held 20 cycles -> digit1=4 only; no capture of 3.
- anode=FC held 20 cycles -> anode_err=1, digits unchanged. Then assert clear for 1 cycle -> anode_err=0.
- anode=FB, cathode=7F (all segments off) held 20 cycles -> pat_err=1, seen[2]=0. Then anode=FF for 20 cycles -> no new error.
- Seven digits captured, assert reset for 1 cycle -> all outputs 0. Capturing only the remaining digit produces no frame_valid.
